multi_mod_counter: RTL

MULTI_MOD_COUNTER -- requirements
Module: multi_mod_counter

---
 rtl/multi_mod_counter_digit.sv | 72 +++++++
 rtl/multi_mod_counter.sv | 94 +++++++++
 2 files changed

// File: rtl/multi_mod_counter_digit.sv
// -----------------------------------------------------------------------------
// mod_digit
// One WIDTH-bit digit of a cascaded modulo counter. State changes on the
// falling edge of CLK; RST clears the digit asynchronously.
//
// Ports:
//   CLK      in   clock, falling edge active
//   RST      in   asynchronous active-high reset (digit -> 0)
//   CLR      in   synchronous clear (digit -> 0), beats LOAD and STEP
//   LOAD     in   synchronous load of D, beats STEP
//   D        in   load value; anything >= MODULUS loads as 0
//   STEP     in   advance by one in the direction given by UP
//   UP       in   1 = count up, 0 = count down
//   Q        out  registered digit value, always < MODULUS
//   AT_TERM  out  digit sits at its terminal value for the current direction
//                 (MODULUS-1 when counting up, 0 when counting down)
// -----------------------------------------------------------------------------
module mod_digit #(
  parameter int MODULUS = 5,
  parameter int WIDTH   = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CLR,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  input  logic             STEP,
  input  logic             UP,
  output logic [WIDTH-1:0] Q,
  output logic             AT_TERM
);

  localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ZERO_VAL = '0;
  localparam logic [WIDTH-1:0] ONE_VAL  = WIDTH'(1);
  // One extra bit so that MODULUS == 2**WIDTH is representable.
  localparam logic [WIDTH:0]   MOD_EXT  = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_load_val;
  logic [WIDTH-1:0] w_next_step;
  logic             w_d_in_range;

  // Out-of-range load values are forced to 0 so Q can never leave 0..MODULUS-1.
  assign w_d_in_range = ({1'b0, D} < MOD_EXT);
  assign w_load_val   = w_d_in_range ? D : ZERO_VAL;

  always_comb begin
    w_next_step = r_q;
    if (UP) begin
      w_next_step = (r_q == MAX_VAL) ? ZERO_VAL : (r_q + ONE_VAL);
    end else begin
      w_next_step = (r_q == ZERO_VAL) ? MAX_VAL : (r_q - ONE_VAL);
    end
  end

  always_ff @(negedge CLK or posedge RST) begin
    if (RST) begin
      r_q <= ZERO_VAL;
    end else if (CLR) begin
      r_q <= ZERO_VAL;
    end else if (LOAD) begin
      r_q <= w_load_val;
    end else if (STEP) begin
      r_q <= w_next_step;
    end
  end

  assign Q       = r_q;
  assign AT_TERM = UP ? (r_q == MAX_VAL) : (r_q == ZERO_VAL);

endmodule

// File: rtl/multi_mod_counter.sv
// -----------------------------------------------------------------------------
// multi_mod_counter
// DIGITS cascaded modulo-MODULUS digits of WIDTH bits each, counting up or
// down on the falling edge of CLK, with a sticky wrap-around flag.
//
// Ports:
//   CLK       in   clock, falling edge active
//   RST       in   asynchronous active-high reset (Q -> 0, OVF -> 0)
//   CLR       in   synchronous clear of all digits and OVF
//   LOAD      in   synchronous parallel load from LOAD_VAL (OVF untouched)
//   LOAD_VAL  in   load value, digit k at [k*WIDTH +: WIDTH], digit 0 = LSD
//   EN        in   count enable, carry-in to digit 0
//   UP        in   1 = count up, 0 = count down
//   Q         out  registered count, same packing as LOAD_VAL
//   TC        out  combinational terminal count: EN and every digit terminal
//   OVF       out  sticky wrap flag, cleared only by RST or CLR
//
// Priority at each falling edge: RST > CLR > LOAD > EN > hold.
// -----------------------------------------------------------------------------
module multi_mod_counter #(
  parameter int DIGITS  = 2,
  parameter int MODULUS = 5,
  parameter int WIDTH   = 3
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    CLR,
  input  logic                    LOAD,
  input  logic [DIGITS*WIDTH-1:0] LOAD_VAL,
  input  logic                    EN,
  input  logic                    UP,
  output logic [DIGITS*WIDTH-1:0] Q,
  output logic                    TC,
  output logic                    OVF
);

  // Reject parameter sets that cannot be built correctly.
  if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
    $error("multi_mod_counter: DIGITS must be 1..8");
  end
  if (WIDTH < 1 || WIDTH > 8) begin : g_bad_width
    $error("multi_mod_counter: WIDTH must be 1..8");
  end
  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
    $error("multi_mod_counter: MODULUS must be 2..2**WIDTH");
  end

  logic [DIGITS-1:0] w_at_term;
  logic [DIGITS-1:0] w_step;
  logic              w_tc;
  logic              r_ovf;

  // Each digit's STEP is a flat AND of EN and every lower AT_TERM, so there
  // is no carry ripple through digit registers.
  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    if (k == 0) begin : g_lsd
      assign w_step[k] = EN;
    end else begin : g_upper
      assign w_step[k] = EN & (&w_at_term[k-1:0]);
    end

    mod_digit #(
      .MODULUS (MODULUS),
      .WIDTH   (WIDTH)
    ) u_digit (
      .CLK     (CLK),
      .RST     (RST),
      .CLR     (CLR),
      .LOAD    (LOAD),
      .D       (LOAD_VAL[k*WIDTH +: WIDTH]),
      .STEP    (w_step[k]),
      .UP      (UP),
      .Q       (Q[k*WIDTH +: WIDTH]),
      .AT_TERM (w_at_term[k])
    );
  end

  assign w_tc = EN & (&w_at_term);

  // TC at an edge with no CLR/LOAD means every digit wraps: record it.
  always_ff @(negedge CLK or posedge RST) begin
    if (RST) begin
      r_ovf <= 1'b0;
    end else if (CLR) begin
      r_ovf <= 1'b0;
    end else if (!LOAD && w_tc) begin
      r_ovf <= 1'b1;
    end
  end

  assign TC  = w_tc;
  assign OVF = r_ovf;

endmodule
